bram_bus_adapter: RTL

//  Valid/ready bus slave placed directly upstream of raw_block_ram in the dev sim.

---
 rtl/bram_bus_pkg.sv | 17 +
 rtl/bram_resp_fifo.sv | 48 ++++
 rtl/bram_bus_adapter.sv | 91 +++++++++
 3 files changed

// File: rtl/bram_bus_pkg.sv
// Shared types and helpers for the block-RAM bus adapter.
// Response entries are sized for the default 4 x 8-bit word.
package bram_bus_pkg;

   localparam int dbits = 32;

   typedef struct packed {
      logic             err;
      logic [dbits-1:0] rdata;
   } resp_t;

   // True when the byte offset lands inside a window of 2**span bytes.
   function automatic logic in_window(input logic [31:0] off, input int unsigned span);
      return (off >> span) == 32'd0;
   endfunction

endpackage

// File: rtl/bram_resp_fifo.sv
// Strict-order response FIFO with registered count.
// A non-power-of-two depth is allowed; the pointers wrap explicitly.
module bram_resp_fifo #(
   parameter int depth = 3,
   parameter int width = 33,
   localparam int cw = $clog2(depth + 1),
   localparam int pw = $clog2(depth)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [width-1:0] push_data,
   input  logic             pop,
   output logic [width-1:0] pop_data,
   output logic [cw-1:0]    count,
   output logic             full
);

   logic [width-1:0] mem [depth];
   logic [pw-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full     = (count == cw'(depth));
   assign do_pop   = pop && (count != '0);
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == pw'(depth - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == pw'(depth - 1)) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/bram_bus_adapter.sv
// Valid/ready slave in front of a 1-cycle-latency block RAM.
// Decodes the byte address window and queues responses so the consumer may stall.
module bram_bus_adapter
   import bram_bus_pkg::*;
#(
   parameter int          abits      = 8,
   parameter int          dbytes     = 4,
   parameter int          blen       = 8,
   parameter logic [31:0] base_addr  = 32'h0,
   parameter int          fifo_depth = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [31:0]            req_addr,
   input  logic [dbytes-1:0]      req_we,
   input  logic [dbytes*blen-1:0] req_wdata,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [dbytes*blen-1:0] resp_rdata,
   output logic                   resp_err,
   output logic [dbytes-1:0]      ram_we,
   output logic [abits-1:0]       ram_addr,
   output logic [dbytes*blen-1:0] ram_wdata,
   input  logic [dbytes*blen-1:0] ram_rdata
);

   localparam int lsb  = $clog2(dbytes);
   localparam int span = abits + lsb;
   localparam int cw   = $clog2(fifo_depth + 1);

   logic [31:0]   off;
   logic          hit, accept;
   logic          inflight, fl_write, fl_err;
   logic [cw-1:0] count;
   logic [cw:0]   occ;
   logic          fifo_full, pop;
   resp_t         push_entry, head;

   assign off      = req_addr - base_addr;
   assign hit      = in_window(off, span);
   assign ram_addr = off[span-1:lsb];
   assign ram_wdata = req_wdata;

   // Ready counts the in-flight slot so a RAM read always has FIFO room to land.
   assign occ       = {1'b0, count} + {{cw{1'b0}}, inflight};
   assign req_ready = !rst && (occ < (cw+1)'(fifo_depth));
   assign accept    = req_valid && req_ready;
   assign ram_we    = (accept && hit) ? req_we : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= 1'b0;
         fl_write <= 1'b0;
         fl_err   <= 1'b0;
      end else begin
         inflight <= accept;
         fl_write <= |req_we;
         fl_err   <= !hit;
      end
   end

   assign push_entry.err   = fl_err;
   assign push_entry.rdata = (fl_write || fl_err) ? '0 : ram_rdata;

   assign resp_valid = (count != '0);
   assign pop        = resp_valid && resp_ready;

   bram_resp_fifo #(
      .depth (fifo_depth),
      .width ($bits(resp_t))
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head),
      .count     (count),
      .full      (fifo_full)
   );

   // Storage behind an empty FIFO is stale; keep the bus quiet instead.
   assign resp_rdata = resp_valid ? head.rdata : '0;
   assign resp_err   = resp_valid && head.err;

   logic unused;
   assign unused = fifo_full;

endmodule
